// File: rtl/core_mem.sv
// MEM pipeline stage: issues one load/store at a time on a req/ack bus and
// registers the stage result for writeback and forwarding.
module core_mem (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [63:0] ex_out,
  input  logic [63:0] ex_B_data,
  input  logic [4:0]  ex_W_regnum,
  input  logic        ex_write_enable,
  input  logic [1:0]  ex_load_type,
  input  logic [1:0]  ex_store_type,
  input  logic        ex_signed_byte,
  input  logic        ex_signed_word,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [63:0] MEM_data,
  output logic [4:0]  MEM_W_regnum,
  output logic        MEM_write_enable,
  output logic        addr_err,
  output logic        state_dbg
);

  // Bus handshake: mem_req rises on the edge after launch and stays high,
  // with we/addr/wdata/be frozen, until the cycle mem_ack is sampled high.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state, state_nxt;

  logic       is_store, is_mem, misalign, launch;
  logic [1:0] size;
  logic [2:0] off;
  logic [7:0] be;
  logic [63:0] wdata;

  logic [1:0] l_size;
  logic [2:0] l_off;
  logic       l_sb, l_sw, l_we, latched_flush;
  logic [4:0] l_regnum;
  logic [7:0]  byte_sel;
  logic [31:0] word_sel;
  logic [63:0] ld_data;

  // An op with both load and store type set is executed as the store.
  assign is_store = |ex_store_type;
  assign is_mem   = is_store | (|ex_load_type);
  assign size     = is_store ? ex_store_type : ex_load_type;
  assign off      = ex_out[2:0];

  always_comb begin
    misalign = 1'b0;
    be       = 8'h00;
    wdata    = ex_B_data;
    case (size)
      2'b01: begin
        be    = 8'h01 << off;
        wdata = {8{ex_B_data[7:0]}};
      end
      2'b10: begin
        misalign = (off[1:0] != 2'b00);
        be       = 8'h0F << off;
        wdata    = {2{ex_B_data[31:0]}};
      end
      2'b11: begin
        misalign = (off != 3'b000);
        be       = 8'hFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = WAIT;
      WAIT:    if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    launch = (state == IDLE) && is_mem && !misalign && !flush;
    stall  = 1'b0;
    if (!reset) stall = (state == IDLE) ? launch : !mem_ack;
  end

  assign state_dbg = (state == WAIT);

  assign byte_sel = mem_rdata[{l_off, 3'b000} +: 8];
  assign word_sel = l_off[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  always_comb begin
    case (l_size)
      2'b01:   ld_data = {{56{l_sb & byte_sel[7]}}, byte_sel};
      2'b10:   ld_data = {{32{l_sw & word_sel[31]}}, word_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= 64'd0;
      mem_wdata        <= 64'd0;
      mem_be           <= 8'h00;
      MEM_data         <= 64'd0;
      MEM_W_regnum     <= 5'd0;
      MEM_write_enable <= 1'b0;
      addr_err         <= 1'b0;
      latched_flush    <= 1'b0;
      l_size           <= 2'b00;
      l_off            <= 3'b000;
      l_sb             <= 1'b0;
      l_sw             <= 1'b0;
      l_we             <= 1'b0;
      l_regnum         <= 5'd0;
    end else begin
      addr_err <= 1'b0;
      if (state == IDLE) begin
        if (!is_mem) begin
          MEM_data         <= ex_out;
          MEM_W_regnum     <= ex_W_regnum;
          MEM_write_enable <= ex_write_enable & ~flush;
        end else if (flush) begin
          MEM_write_enable <= 1'b0;
        end else if (misalign) begin
          MEM_write_enable <= 1'b0;
          addr_err         <= 1'b1;
        end else begin
          mem_req          <= 1'b1;
          mem_we           <= is_store;
          mem_addr         <= {ex_out[63:3], 3'b000};
          mem_wdata        <= wdata;
          mem_be           <= be;
          l_size           <= size;
          l_off            <= off;
          l_sb             <= ex_signed_byte;
          l_sw             <= ex_signed_word;
          l_we             <= ex_write_enable;
          l_regnum         <= ex_W_regnum;
          latched_flush    <= 1'b0;
          MEM_write_enable <= 1'b0;
        end
      end else begin
        if (flush) latched_flush <= 1'b1;
        if (mem_ack) begin
          mem_req       <= 1'b0;
          latched_flush <= 1'b0;
          if (mem_we) begin
            MEM_write_enable <= 1'b0;
          end else begin
            MEM_data         <= ld_data;
            MEM_W_regnum     <= l_regnum;
            MEM_write_enable <= l_we & ~(latched_flush | flush);
          end
        end
      end
    end
  end

endmodule

// File: doc/core_mem.md
CORE_MEM -- requirements
Module: core_MEM

Interface
REQ-001 clock  in  1  sole clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 flush  in  1  kill the instruction currently presented by EX.
REQ-004 ex_out  in  64  EX result: load/store byte address, or ALU result for non-memory ops.
REQ-005 ex_B_data  in  64  store data.
REQ-006 ex_W_regnum  in  5  destination register.
REQ-007 ex_write_enable  in  1  register write request.
REQ-008 ex_load_type / ex_store_type  in  2 each  00 none, 01 byte, 10 word (32b), 11 dword.
REQ-009 ex_signed_byte / ex_signed_word  in  1 each  sign-extend byte/word loads when 1, zero-extend when 0.
REQ-010 mem_req  out  1  bus request, held until mem_ack.
REQ-011 mem_we  out  1  1 = store.
REQ-012 mem_addr  out  64  access address, bits [2:0] forced to 0.
REQ-013 mem_wdata  out  64  store data, lane-replicated.
REQ-014 mem_be  out  8  byte enables.
REQ-015 mem_rdata  in  64  read data, valid with mem_ack.
REQ-016 mem_ack  in  1  one-cycle completion pulse.
REQ-017 stall  out  1  upstream holds EX inputs while 1.
REQ-018 MEM_data  out  64  registered stage result (WB and forwarding).
REQ-019 MEM_W_regnum  out  5  registered.
REQ-020 MEM_write_enable  out  1  registered.
REQ-021 addr_err  out  1  registered one-cycle misalignment pulse.

Function
REQ-022 Memory op = load_type or store_type nonzero; both nonzero is illegal and treated as a store.
REQ-023 FSM states: IDLE and WAIT only.
REQ-024 Non-memory op in IDLE: next edge MEM_data<=ex_out, MEM_W_regnum<=ex_W_regnum, MEM_write_enable<=ex_write_enable & ~flush; stall=0; latency 1.
REQ-025 Aligned memory op in IDLE without flush: stall=1 combinationally; next edge latch request, state->WAIT, MEM_write_enable<=0.
REQ-026 WAIT: mem_req=1; mem_we, mem_addr, mem_wdata, mem_be held constant; stall=~mem_ack.
REQ-027 WAIT with mem_ack=1: next edge state->IDLE, mem_req->0. A load writes the extracted data to MEM_data with MEM_write_enable<=latched write_enable & ~latched_flush. A store sets MEM_write_enable<=0. Minimum load latency is 2 cycles.
REQ-028 Byte lanes, off=ex_out[2:0].
- byte: be=1<<off, wdata=B[7:0] replicated x8.
- word: be=0x0F<<off, wdata=B[31:0] replicated x2.
- dword: be=0xFF.
REQ-029 Load extract.
- byte: rdata[8*off+7:8*off], extended to 64 bits.
- word: rdata[32*off[2]+31:32*off[2]], extended to 64 bits.
- dword: rdata unchanged.
REQ-030 Misaligned access is word with off[1:0]!=0 or dword with off!=0. On misalignment: no bus request; next edge addr_err<=1 for one cycle and MEM_write_enable<=0; stall=0.
REQ-031 flush in IDLE: no request is launched; next edge MEM_write_enable<=0 and addr_err<=0.
REQ-032 flush during WAIT: set latched_flush; the access still completes, and its result is discarded per REQ-027.
REQ-033 mem_ack in IDLE is ignored.
REQ-034 Back-to-back memory ops: the op held during stall is re-sampled in IDLE on the cycle after the ack edge; the bus sees no overlapping requests.

Reset
REQ-035 On reset: state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, MEM_data, MEM_W_regnum, MEM_write_enable, addr_err and latched_flush are all 0.
REQ-036 Reset asserted in WAIT drops mem_req immediately, without waiting for a clock edge; a later mem_ack is ignored.
REQ-037 stall=0 while reset is asserted.

Verification
REQ-038 ALU op, ex_out=0x1234, W=5, we=1 -> next cycle MEM_data=0x1234, MEM_W_regnum=5, MEM_write_enable=1, stall never 1.
REQ-039 Signed byte load, addr=0x1003, ack 3 cycles after req, rdata=0x00000000_80000000 -> mem_addr=0x1000, be=0x08, stall high 4 cycles, MEM_data=0xFFFFFFFF_FFFFFF80.
REQ-040 Word store, addr=0x2004, B=0xAABBCCDD -> mem_we=1, be=0xF0, wdata=0xAABBCCDD_AABBCCDD, MEM_write_enable=0.
REQ-041 Dword load at 0x3002 -> no mem_req, addr_err=1 for exactly one cycle, stall=0.
REQ-042 Load with flush asserted during WAIT -> access completes on ack, MEM_write_enable=0.
REQ-043 Reset asserted mid-WAIT -> mem_req=0 before the next edge, state IDLE, all outputs 0.
